// File: rtl/div_iter_if.sv
// Handshake and operand bundle between the execute-stage FU and the iterative divider.
interface div_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, srca, srcb, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, srca, srcb, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider for MIPS DIV/DIVU: one quotient bit per cycle, 33-cycle fixed latency,
// sign fix-up on the final iteration, all outputs registered.
module div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input logic        clk,
  input logic        reset,
  div_iter_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CntW-1:0]  cnt_q;
  logic             quo_neg_q;
  logic             rem_neg_q;
  logic             dvz_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] hi_fix;
  logic [WIDTH-1:0] lo_fix;

  always_comb begin
    a_abs   = (bus.is_signed && bus.srca[WIDTH-1]) ? -bus.srca : bus.srca;
    b_abs   = (bus.is_signed && bus.srcb[WIDTH-1]) ? -bus.srcb : bus.srcb;
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    // Borrow out of the trial subtract means the divisor did not fit: restore.
    qbit    = ~trial[WIDTH];
    rem_nxt = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], qbit};
    hi_fix  = rem_neg_q ? -rem_nxt : rem_nxt;
    // Divide by zero leaves |srca| as remainder, so hi returns the raw dividend after fix-up.
    if (dvz_q) begin
      lo_fix = '1;
    end else begin
      lo_fix = quo_neg_q ? -quo_nxt : quo_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dvz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (bus.flush) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q   <= StRun;
            busy_q    <= 1'b1;
            rem_q     <= '0;
            quo_q     <= a_abs;
            dvs_q     <= b_abs;
            cnt_q     <= CntW'(WIDTH - 1);
            quo_neg_q <= bus.is_signed & (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
            rem_neg_q <= bus.is_signed & bus.srca[WIDTH-1];
            dvz_q     <= (bus.srcb == '0);
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          if (cnt_q == '0) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= hi_fix;
            lo_q    <= lo_fix;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: expected results are queued on issue and compared on done,
// including the cycle in which done must appear.
module tb_div_iter;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;
  exp_t sb_q[$];
  exp_t last_exp;

  div_iter_if #(.WIDTH(32)) bus ();

  div_iter #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                 input int c);
    exp_t e;
    e.cyc = c;
    if (b == 32'd0) begin
      e.lo = 32'hFFFF_FFFF;
      e.hi = a;
    end else if (!sgn) begin
      e.lo = a / b;
      e.hi = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.lo = 32'h8000_0000;
      e.hi = 32'd0;
    end else begin
      e.lo = $signed(a) / $signed(b);
      e.hi = $signed(a) % $signed(b);
    end
    return e;
  endfunction

  // Drive a start for the current cycle and queue its expected result.
  task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b, output int c);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.srca      = a;
    bus.srcb      = b;
    c             = cyc;
    sb_q.push_back(model(sgn, a, b, c));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      check_val("drain_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("done_cycle", 64'(cyc), 64'(e.cyc + 33));
        check_val("lo", {32'd0, bus.lo}, {32'd0, e.lo});
        check_val("hi", {32'd0, bus.hi}, {32'd0, e.hi});
        last_exp = e;
      end
    end
  end

  initial begin
    #2_000_000;
    check_val("global_timeout", 64'd1, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int c;
    int c2;
    total         = 0;
    bad           = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.flush     = 1'b0;
    bus.is_signed = 1'b0;
    bus.srca      = '0;
    bus.srcb      = '0;
    last_exp.hi   = '0;
    last_exp.lo   = '0;
    last_exp.cyc  = 0;

    repeat (2) @(negedge clk);
    check_val("rst_busy", {63'd0, bus.busy}, 64'd0);
    check_val("rst_done", {63'd0, bus.done}, 64'd0);
    check_val("rst_hi", {32'd0, bus.hi}, 64'd0);
    check_val("rst_lo", {32'd0, bus.lo}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    // DIVU 100/7 with cycle-by-cycle busy profile
    issue(1'b0, 32'd100, 32'd7, c);
    step();
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      check_val("busy_profile", {63'd0, bus.busy}, {63'd0, (k <= 32)});
    end
    drain();

    // Signed cases, overflow, full-scale unsigned, divide by zero
    step();
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, c); step(); drain();
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, c); step(); drain();
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, c); step(); drain();
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, c); step(); drain();
    issue(1'b0, 32'd1234, 32'd0, c); step(); drain();
    issue(1'b1, 32'd1234, 32'd0, c); step(); drain();
    for (int i = 0; i < 4; i++) begin
      issue(1'(i), $urandom, $urandom_range(1, 1000), c);
      step();
      drain();
    end
    issue(1'b0, 32'd1234, 32'd0, c); step(); drain();

    // Flush in cycle 10, then 9/4 issued the cycle after
    step();
    issue(1'b0, 32'd100, 32'd7, c);
    step();
    goto(c + 10);
    bus.flush = 1'b1;
    step();
    void'(sb_q.pop_back());
    issue(1'b0, 32'd9, 32'd4, c2);
    @(negedge clk);
    check_val("flush_busy", {63'd0, bus.busy}, 64'd0);
    check_val("flush_start_cycle", 64'(c2), 64'(c + 11));
    check_val("flush_lo_hold", {32'd0, bus.lo}, {32'd0, last_exp.lo});
    check_val("flush_hi_hold", {32'd0, bus.hi}, {32'd0, last_exp.hi});
    step();
    drain();

    // start during RUN must be ignored
    step();
    issue(1'b1, 32'hFFFF_FF9C, 32'd7, c);
    step();
    goto(c + 5);
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.srca      = 32'd5;
    bus.srcb      = 32'd1;
    step();
    drain();

    // Back-to-back issue in the DONE cycle
    step();
    issue(1'b0, 32'd77, 32'd3, c);
    step();
    goto(c + 33);
    issue(1'b0, 32'd50, 32'd5, c2);
    step();
    drain();

    // Asynchronous reset mid-RUN
    issue(1'b0, 32'd1000, 32'd3, c);
    step();
    goto(c + 20);
    reset = 1'b1;
    #1;
    check_val("areset_busy", {63'd0, bus.busy}, 64'd0);
    check_val("areset_done", {63'd0, bus.done}, 64'd0);
    check_val("areset_hi", {32'd0, bus.hi}, 64'd0);
    check_val("areset_lo", {32'd0, bus.lo}, 64'd0);
    sb_q.delete();
    step();
    reset = 1'b0;
    repeat (40) step();
    check_val("post_reset_busy", {63'd0, bus.busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
